// File: rtl/scariv_issue_age_picker_pkg.sv
// Shared types, default sizes and helpers for the scheduler age picker.
// Optional feature macro used by the top level: SCARIV_PICK_PERF_EN.
package scariv_issue_age_picker_pkg;

   typedef enum logic [1:0] {
      PIPE_ALU,
      PIPE_LSU,
      PIPE_BRU,
      PIPE_CSU
   } pipe_type_t;

   localparam int ALU_ENTRY_SIZE = 8;
   localparam int LSU_ENTRY_SIZE = 16;
   localparam int BRU_ENTRY_SIZE = 8;
   localparam int CSU_ENTRY_SIZE = 4;
   localparam int DISP_IN_PORT   = 2;

   function automatic int conf_entry_size(input pipe_type_t pipe);
      int size;
      case (pipe)
         PIPE_LSU: size = LSU_ENTRY_SIZE;
         PIPE_BRU: size = BRU_ENTRY_SIZE;
         PIPE_CSU: size = CSU_ENTRY_SIZE;
         default:  size = ALU_ENTRY_SIZE;
      endcase
      return size;
   endfunction

   // Callers zero-extend to 32 bits; entry counts never exceed 32.
   function automatic logic [4:0] oh2bin(input logic [31:0] oh);
      logic [4:0] bin;
      bin = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) bin = bin | 5'(i);
      end
      return bin;
   endfunction

   function automatic logic [5:0] popcnt(input logic [31:0] vec);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + 6'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/scariv_issue_age_picker_if.sv
// Dispatch / pick / release bundle between a scheduler's entries and its age picker.
interface scariv_issue_age_picker_if
   import scariv_issue_age_picker_pkg::*;
#(
   parameter int ENTRY_SIZE = ALU_ENTRY_SIZE,
   parameter int IN_PORT    = DISP_IN_PORT
);
   localparam int IDX_W = $clog2(ENTRY_SIZE);
   localparam int CNT_W = IDX_W + 1;

   logic [IN_PORT-1:0]                 i_disp_valid;
   logic                               o_disp_ready;
   logic [IN_PORT-1:0][ENTRY_SIZE-1:0] o_put_oh;
   logic [ENTRY_SIZE-1:0]              i_entry_ready;
   logic                               i_pipe_stall;
   logic                               o_pick_valid;
   logic [ENTRY_SIZE-1:0]              o_picked_oh;
   logic [IDX_W-1:0]                   o_picked_idx;
   logic [ENTRY_SIZE-1:0]              i_entry_finish;
   logic [CNT_W-1:0]                   o_free_cnt;

   modport master (
      output i_disp_valid, i_entry_ready, i_pipe_stall, i_entry_finish,
      input  o_disp_ready, o_put_oh, o_pick_valid, o_picked_oh, o_picked_idx, o_free_cnt
   );

   modport slave (
      input  i_disp_valid, i_entry_ready, i_pipe_stall, i_entry_finish,
      output o_disp_ready, o_put_oh, o_pick_valid, o_picked_oh, o_picked_idx, o_free_cnt
   );

endinterface

// File: rtl/scariv_issue_age_picker_age_matrix.sv
// Age matrix: row i bit j set means entry i is older than entry j.
// Holds the put/release update and the combinational oldest-candidate select.
module scariv_issue_age_picker_age_matrix
   import scariv_issue_age_picker_pkg::*;
#(
   parameter int ENTRY_SIZE = ALU_ENTRY_SIZE,
   parameter int IN_PORT    = DISP_IN_PORT
)(
   input  logic                               i_clk,
   input  logic                               i_reset_n,
   input  logic [ENTRY_SIZE-1:0]              i_used,
   input  logic [IN_PORT-1:0][ENTRY_SIZE-1:0] i_put_oh,
   input  logic [ENTRY_SIZE-1:0]              i_fin,
   input  logic [ENTRY_SIZE-1:0]              i_cand,
   output logic [ENTRY_SIZE-1:0]              o_oldest_oh
);

   typedef logic [ENTRY_SIZE-1:0] sched_age_t;

   sched_age_t w_age [ENTRY_SIZE];
   sched_age_t w_younger [IN_PORT];
   sched_age_t w_put_all;

   // Entries put by later slots of the same group are younger than this slot's entry.
   generate
      for (genvar gi = 0; gi < IN_PORT; gi++) begin : g_younger
         if (gi == IN_PORT - 1) begin : g_last
            assign w_younger[gi] = '0;
         end else begin : g_chain
            assign w_younger[gi] = w_younger[gi+1] | i_put_oh[gi+1];
         end
      end
   endgenerate

   always_comb begin
      w_put_all = '0;
      for (int p = 0; p < IN_PORT; p++) begin
         w_put_all = w_put_all | i_put_oh[p];
      end
   end

   generate
      for (genvar gi = 0; gi < ENTRY_SIZE; gi++) begin : g_row
         sched_age_t r_age_row;
         sched_age_t w_new_row;
         sched_age_t w_row_next;
         sched_age_t w_col;

         always_comb begin
            w_new_row = '0;
            for (int p = 0; p < IN_PORT; p++) begin
               if (i_put_oh[p][gi]) w_new_row = w_new_row | w_younger[p];
            end
         end

         // Surviving entries become older than every new put; released columns drop out.
         always_comb begin
            if (w_put_all[gi]) begin
               w_row_next = w_new_row;
            end else if (!i_used[gi] || i_fin[gi]) begin
               w_row_next = '0;
            end else begin
               w_row_next = (r_age_row | w_put_all) & ~i_fin;
            end
         end

         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               r_age_row <= '0;
            end else begin
               r_age_row <= w_row_next;
            end
         end

         assign w_age[gi] = r_age_row;

         always_comb begin
            w_col = '0;
            for (int j = 0; j < ENTRY_SIZE; j++) begin
               w_col[j] = w_age[j][gi];
            end
         end

         // Wins when no other candidate is older.
         assign o_oldest_oh[gi] = i_cand[gi] & ~|(i_cand & w_col);
      end
   endgenerate

endmodule

// File: rtl/scariv_issue_age_picker.sv
// Free-list allocation and oldest-first pick for one scheduler's entries.
// Define SCARIV_PICK_PERF_EN to add saturating full/stall cycle counters.
module scariv_issue_age_picker
   import scariv_issue_age_picker_pkg::*;
#(
   parameter int ENTRY_SIZE = ALU_ENTRY_SIZE,
   parameter int IN_PORT    = DISP_IN_PORT
)(
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   scariv_issue_age_picker_if.slave  pick_if
`ifdef SCARIV_PICK_PERF_EN
   ,
   output logic [31:0]               o_perf_full_cyc,
   output logic [31:0]               o_perf_stall_cyc
`endif
);

   localparam int IDX_W = $clog2(ENTRY_SIZE);
   localparam int CNT_W = IDX_W + 1;

   logic [ENTRY_SIZE-1:0]              r_used;
   logic [CNT_W-1:0]                   r_free_cnt;
   logic                               w_disp_ready;
   logic [ENTRY_SIZE-1:0]              w_avail [IN_PORT];
   logic [IN_PORT-1:0][ENTRY_SIZE-1:0] w_put_oh;
   logic [ENTRY_SIZE-1:0]              w_put_all;
   logic [ENTRY_SIZE-1:0]              w_fin_vld;
   logic [ENTRY_SIZE-1:0]              w_cand;
   logic [ENTRY_SIZE-1:0]              w_oldest_oh;
   logic [ENTRY_SIZE-1:0]              w_picked_oh;
   logic                               w_pick_valid;
   logic [CNT_W-1:0]                   w_put_cnt;
   logic [CNT_W-1:0]                   w_fin_cnt;

   // Registered count gates the whole group, so the chain below never runs dry.
   assign w_disp_ready = (r_free_cnt >= CNT_W'(IN_PORT));
   assign w_avail[0]   = ~r_used;

   generate
      for (genvar gi = 0; gi < IN_PORT; gi++) begin : g_slot
         logic [ENTRY_SIZE-1:0] w_lowest;
         assign w_lowest      = w_avail[gi] & (-w_avail[gi]);
         assign w_put_oh[gi]  = (w_disp_ready && pick_if.i_disp_valid[gi]) ? w_lowest : '0;
         if (gi < IN_PORT - 1) begin : g_chain
            assign w_avail[gi+1] = w_avail[gi] & ~w_put_oh[gi];
         end
      end
   endgenerate

   always_comb begin
      w_put_all = '0;
      for (int p = 0; p < IN_PORT; p++) begin
         w_put_all = w_put_all | w_put_oh[p];
      end
   end

   // Finishes on idle entries are dropped here so they cannot corrupt count or age.
   assign w_fin_vld = pick_if.i_entry_finish & r_used;
   assign w_cand    = pick_if.i_entry_ready & r_used;
   assign w_put_cnt = CNT_W'(popcnt(32'(w_put_all)));
   assign w_fin_cnt = CNT_W'(popcnt(32'(w_fin_vld)));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_used     <= '0;
         r_free_cnt <= CNT_W'(ENTRY_SIZE);
      end else begin
         r_used     <= (r_used & ~w_fin_vld) | w_put_all;
         r_free_cnt <= r_free_cnt - w_put_cnt + w_fin_cnt;
      end
   end

   scariv_issue_age_picker_age_matrix #(
      .ENTRY_SIZE (ENTRY_SIZE),
      .IN_PORT    (IN_PORT)
   ) u_age_matrix (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_used      (r_used),
      .i_put_oh    (w_put_oh),
      .i_fin       (w_fin_vld),
      .i_cand      (w_cand),
      .o_oldest_oh (w_oldest_oh)
   );

   assign w_pick_valid = (|w_cand) & ~pick_if.i_pipe_stall;
   assign w_picked_oh  = w_pick_valid ? w_oldest_oh : '0;

   assign pick_if.o_disp_ready = w_disp_ready;
   assign pick_if.o_put_oh     = w_put_oh;
   assign pick_if.o_pick_valid = w_pick_valid;
   assign pick_if.o_picked_oh  = w_picked_oh;
   assign pick_if.o_picked_idx = IDX_W'(oh2bin(32'(w_picked_oh)));
   assign pick_if.o_free_cnt   = r_free_cnt;

`ifdef SCARIV_PICK_PERF_EN
   logic [31:0] r_perf_full_cyc;
   logic [31:0] r_perf_stall_cyc;
   logic        w_full_evt;
   logic        w_stall_evt;

   assign w_full_evt  = !w_disp_ready && (|pick_if.i_disp_valid);
   assign w_stall_evt = (|w_cand) && pick_if.i_pipe_stall;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_perf_full_cyc  <= '0;
         r_perf_stall_cyc <= '0;
      end else begin
         if (w_full_evt && (r_perf_full_cyc != '1)) r_perf_full_cyc <= r_perf_full_cyc + 32'd1;
         if (w_stall_evt && (r_perf_stall_cyc != '1)) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      end
   end

   assign o_perf_full_cyc  = r_perf_full_cyc;
   assign o_perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule

// File: tb/tb_scariv_issue_age_picker.sv
// Scoreboard bench for scariv_issue_age_picker: an age-ordered queue model predicts
// allocation, pick and free count each cycle; predictions are queued then compared.
module tb_scariv_issue_age_picker;

   localparam int ES    = 8;
   localparam int IP    = 2;
   localparam int IDX_W = $clog2(ES);
   localparam int CNT_W = IDX_W + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   scariv_issue_age_picker_if #(.ENTRY_SIZE(ES), .IN_PORT(IP)) pif ();

`ifdef SCARIV_PICK_PERF_EN
   logic [31:0] perf_full;
   logic [31:0] perf_stall;
`endif

   scariv_issue_age_picker #(
      .ENTRY_SIZE (ES),
      .IN_PORT    (IP)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .pick_if   (pif)
`ifdef SCARIV_PICK_PERF_EN
      ,
      .o_perf_full_cyc  (perf_full),
      .o_perf_stall_cyc (perf_stall)
`endif
   );

   typedef struct {
      logic                    rdy;
      logic [IP-1:0][ES-1:0]   put;
      logic                    pv;
      logic [ES-1:0]           poh;
      logic [IDX_W-1:0]        pidx;
      logic [CNT_W-1:0]        free;
   } exp_t;

   exp_t sb_q[$];
   int   age_q[$];      // model: used entries, oldest first
   int   n_chk = 0;
   int   n_fail = 0;
   int   m_full_cnt = 0;
   int   m_stall_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ES-1:0] model_used();
      logic [ES-1:0] u;
      u = '0;
      for (int q = 0; q < age_q.size(); q++) u[age_q[q]] = 1'b1;
      return u;
   endfunction

   // One cycle: predict, drive, compare mid-cycle, then advance the model on the edge.
   task automatic step(input logic [IP-1:0] dv, input logic [ES-1:0] rdy,
                       input logic st, input logic [ES-1:0] fin);
      exp_t          e;
      exp_t          got;
      logic [ES-1:0] used;
      logic [ES-1:0] avail;
      logic [ES-1:0] cand;
      used   = model_used();
      e.free = CNT_W'(ES - age_q.size());
      e.rdy  = ((ES - age_q.size()) >= IP);
      avail  = ~used;
      e.put  = '0;
      for (int s = 0; s < IP; s++) begin
         if (e.rdy && dv[s]) begin
            for (int j = 0; j < ES; j++) begin
               if (avail[j]) begin
                  e.put[s][j] = 1'b1;
                  avail[j]    = 1'b0;
                  break;
               end
            end
         end
      end
      cand   = rdy & used;
      e.pv   = (cand != '0) && !st;
      e.poh  = '0;
      e.pidx = '0;
      if (e.pv) begin
         for (int q = 0; q < age_q.size(); q++) begin
            if (cand[age_q[q]]) begin
               e.poh[age_q[q]] = 1'b1;
               e.pidx          = IDX_W'(age_q[q]);
               break;
            end
         end
      end
      sb_q.push_back(e);

      pif.i_disp_valid   = dv;
      pif.i_entry_ready  = rdy;
      pif.i_pipe_stall   = st;
      pif.i_entry_finish = fin;
      @(negedge clk);
      got = sb_q.pop_front();
      check_val("disp_ready", 64'(pif.o_disp_ready), 64'(got.rdy));
      check_val("put_oh",     64'(pif.o_put_oh),     64'(got.put));
      check_val("pick_valid", 64'(pif.o_pick_valid), 64'(got.pv));
      check_val("picked_oh",  64'(pif.o_picked_oh),  64'(got.poh));
      check_val("picked_idx", 64'(pif.o_picked_idx), 64'(got.pidx));
      check_val("free_cnt",   64'(pif.o_free_cnt),   64'(got.free));
`ifdef SCARIV_PICK_PERF_EN
      check_val("perf_full",  64'(perf_full),  64'(m_full_cnt));
      check_val("perf_stall", 64'(perf_stall), 64'(m_stall_cnt));
`endif
      $display("[%0t] dv=%b rdy=%h st=%b fin=%h -> ready=%b put=%h pv=%b idx=%0d free=%0d",
               $time, dv, rdy, st, fin, pif.o_disp_ready, pif.o_put_oh,
               pif.o_pick_valid, pif.o_picked_idx, pif.o_free_cnt);
      @(posedge clk);
      #1;
      if (!got.rdy && (dv != '0)) m_full_cnt++;
      if ((cand != '0) && st) m_stall_cnt++;
      for (int q = age_q.size() - 1; q >= 0; q--) begin
         if (fin[age_q[q]]) age_q.delete(q);
      end
      for (int s = 0; s < IP; s++) begin
         for (int j = 0; j < ES; j++) begin
            if (got.put[s][j]) age_q.push_back(j);
         end
      end
   endtask

   task automatic check_reset_state(input string pfx);
      check_val({pfx, "_pick_valid"}, 64'(pif.o_pick_valid), 64'(0));
      check_val({pfx, "_picked_oh"},  64'(pif.o_picked_oh),  64'(0));
      check_val({pfx, "_picked_idx"}, 64'(pif.o_picked_idx), 64'(0));
      check_val({pfx, "_free_cnt"},   64'(pif.o_free_cnt),   64'(ES));
      check_val({pfx, "_disp_ready"}, 64'(pif.o_disp_ready), 64'(1));
      check_val({pfx, "_put_oh"},     64'(pif.o_put_oh),     64'(0));
   endtask

   initial begin
      logic [ES-1:0] used;
      logic [ES-1:0] fin;
      logic [ES-1:0] rdy;
      pif.i_disp_valid   = '0;
      pif.i_entry_ready  = '1;
      pif.i_pipe_stall   = 1'b0;
      pif.i_entry_finish = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Allocation order, invalid slot skipping, oldest-first pick
      step(2'b11, 8'h00, 1'b0, 8'h00);   // entries 0,1
      step(2'b10, 8'h00, 1'b0, 8'h00);   // slot1 alone -> entry 2
      step(2'b00, 8'h06, 1'b0, 8'h00);   // pick 1
      step(2'b00, 8'h05, 1'b0, 8'h00);   // pick 0
      step(2'b01, 8'h00, 1'b0, 8'h00);   // entry 3
      step(2'b11, 8'h00, 1'b0, 8'h00);   // entries 4,5
      step(2'b11, 8'h00, 1'b0, 8'h00);   // entries 6,7 -> full
      // Full: no allocation, picks continue
      step(2'b11, 8'hff, 1'b0, 8'h00);
      step(2'b11, 8'h00, 1'b0, 8'h08);   // finish 3
      step(2'b11, 8'h00, 1'b0, 8'h40);   // free 1: still not ready; finish 6
      step(2'b01, 8'h00, 1'b0, 8'h00);   // free 2: slot0 takes 3
      step(2'b00, 8'h00, 1'b0, 8'h80);   // finish 7
      // Finish 5 in the dispatch cycle; finish of idle entry 6 is ignored
      step(2'b11, 8'h00, 1'b0, 8'h60);
      step(2'b11, 8'h60, 1'b0, 8'h00);   // free {5} only
      step(2'b00, 8'h00, 1'b0, 8'h01);   // finish 0
      step(2'b11, 8'h00, 1'b0, 8'h00);   // entries 0,5
      step(2'b00, 8'h21, 1'b0, 8'h00);
      step(2'b00, 8'h30, 1'b0, 8'h00);
      step(2'b00, 8'h28, 1'b0, 8'h00);
      // Stall suppresses the pick
      step(2'b00, 8'hff, 1'b1, 8'h00);
      step(2'b00, 8'hff, 1'b1, 8'h00);
      step(2'b00, 8'h80, 1'b0, 8'h00);

      // Random legal traffic: finishes only on used entries, never ready in the same cycle
      for (int n = 0; n < 60; n++) begin
         used = model_used();
         fin  = ES'($urandom) & ES'($urandom) & used;
         rdy  = ES'($urandom) & ~fin;
         step(IP'($urandom), rdy, ($urandom_range(0, 3) == 0), fin);
      end

      // Reset in the middle of activity
      step(2'b11, 8'h00, 1'b0, 8'h00);
      pif.i_disp_valid   = 2'b11;
      pif.i_entry_ready  = '1;
      pif.i_pipe_stall   = 1'b0;
      pif.i_entry_finish = '0;
      #1;
      check_val("pre_rst_pick_valid", 64'(pif.o_pick_valid), 64'(age_q.size() != 0));
      rst_n = 1'b0;
      #1;
      pif.i_disp_valid = '0;
      #1;
      check_reset_state("mid_rst");
      age_q.delete();
      m_full_cnt  = 0;
      m_stall_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(2'b01, 8'h00, 1'b0, 8'h00);   // entry 0 first after reset
      step(2'b11, 8'h07, 1'b0, 8'h00);   // entries 1,2; pick 0
      step(2'b00, 8'h06, 1'b0, 8'h00);
      step(2'b00, 8'h07, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/scariv_issue_age_picker.md
Name: scariv_issue_age_picker

Overview:
Allocation and oldest-first issue arbiter for one scheduler of ENTRY_SIZE scariv_sched_entry instances.
- Assigns free entries to incoming dispatch slots and drives each entry's i_put.
- Tracks relative age with an age matrix.
- Each cycle, picks the oldest entry whose o_entry_ready is high and returns i_entry_picked.
- Frees an entry when that entry asserts o_entry_finish.

Parameters:
ENTRY_SIZE, 8, number of scheduler entries managed (2..32).
IN_PORT, 2, dispatch slots per cycle (1..4, at most ENTRY_SIZE).

Ports:
i_clk  input  1  clock.
i_reset_n  input  1  asynchronous, active-low reset.
i_disp_valid  input  IN_PORT  dispatch slot valid; slot 0 is oldest within the group.
o_disp_ready  output  1  at least IN_PORT entries are free (registered count).
o_put_oh  output  IN_PORT x ENTRY_SIZE  one-hot entry chosen per slot; zero when the slot is invalid or not ready.
i_entry_ready  input  ENTRY_SIZE  o_entry_ready of each entry.
i_pipe_stall  input  1  issue pipe cannot accept; suppresses the pick.
o_pick_valid  output  1  a pick was made this cycle.
o_picked_oh  output  ENTRY_SIZE  one-hot entry picked; drives i_entry_picked.
o_picked_idx  output  $clog2(ENTRY_SIZE)  binary form of o_picked_oh.
i_entry_finish  input  ENTRY_SIZE  o_entry_finish of each entry; releases it.
o_free_cnt  output  $clog2(ENTRY_SIZE)+1  registered free-entry count.

Behaviour:
State:
- r_used[ENTRY_SIZE]: entry occupied.
- r_age[ENTRY_SIZE][ENTRY_SIZE]: r_age[i][j]=1 means i is older than j.
- r_free_cnt: free-entry count.

Reset:
- r_used=0, r_age=0, r_free_cnt=ENTRY_SIZE.
- Therefore o_disp_ready=1, o_pick_valid=0, o_picked_oh=0, o_picked_idx=0. o_put_oh is 0 while i_disp_valid=0.

Allocation (combinational, same cycle):
- Only when o_disp_ready=1. Allocation is all-or-nothing; there is no partial allocation.
- Valid slots take free entries (~r_used) in ascending slot order, lowest free index first.
- Invalid slots consume no entry; a later valid slot takes the next lowest free index.
- Allocated entries set r_used on the next edge.

Age update on put of entry k:
- For every j with r_used[j]=1 and no finish this cycle: r_age[j][k]=1.
- Row k is cleared except for same-cycle puts: when slots a<b put entries ka and kb, r_age[ka][kb]=1.

Pick (combinational, 0-cycle latency, because sched_entry samples i_entry_picked in the same cycle as o_entry_ready):
- cand = i_entry_ready & r_used.
- Entry i wins iff cand[i] and there is no cand[j] with r_age[j][i]=1.
- o_pick_valid = |cand & ~i_pipe_stall. o_picked_oh is 0 when o_pick_valid=0.
- Exactly one winner whenever cand is nonzero (the age matrix is a total order over used entries).

Release:
- i_entry_finish[k] clears r_used[k], row k and column k on the next edge.
- A finish for an entry with r_used=0 is ignored.

Free count:
- r_free_cnt_next = r_free_cnt - popcount(allocated) + popcount(i_entry_finish & r_used).
- The count never underflows or overflows.

Simultaneous events:
- An entry finishing in cycle t is not allocatable until t+1. Allocation uses registered r_used only, so there is no combinational path from finish to put.
- Pick and finish on the same entry cannot both be legal; it is ignored for the pick.
- Full (free_cnt < IN_PORT): o_disp_ready=0 and o_put_oh=0. Picks continue.
- Empty: o_pick_valid=0.
- Reset mid-operation clears all state asynchronously. No pending handshake survives.

Optional Feature:
SCARIV_PICK_PERF_EN:
- When defined, adds o_perf_full_cyc and o_perf_stall_cyc (32-bit, saturating at all-ones, reset 0).
  - o_perf_full_cyc counts cycles with o_disp_ready=0 and |i_disp_valid.
  - o_perf_stall_cyc counts cycles with |cand and i_pipe_stall.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- ENTRY_SIZE defaults for each pipe type live in scariv_conf_pkg.
- scariv_pkg gains a sched_age_t typedef (logic [ENTRY_SIZE-1:0] row) and a one-hot-to-binary function.
- Sub-module scariv_age_matrix holds the r_age storage, the put/finish update and the oldest-select logic. The top level holds the free list, free count and allocation.

Test Plan:
1. Reset, then dispatch slots 0 and 1 valid -> o_put_oh[0]=entry0, o_put_oh[1]=entry1; o_free_cnt 8->6 next cycle.
2. Entries 0,1,2 put in that order; i_entry_ready=0b110 -> o_picked_idx=1. Then ready=0b101 -> o_picked_idx=0.
3. Fill all 8 entries -> o_disp_ready=0, o_put_oh=0. i_entry_finish[3] -> next cycle free_cnt=1, o_disp_ready=0 (IN_PORT=2). A second finish -> o_disp_ready=1 and slot0 takes entry 3.
4. Finish entry 5 and dispatch in the same cycle with free set {5} plus one other -> entry 5 is not allocated that cycle. Next cycle it is allocatable, and its age is youngest.
5. i_pipe_stall=1 with ready entries -> o_pick_valid=0 and o_picked_oh=0. With SCARIV_PICK_PERF_EN, o_perf_stall_cyc increments by 1 per cycle.
6. Assert reset mid-burst with entries used and ready -> o_pick_valid=0 immediately, o_free_cnt=8, age cleared. The first post-reset put is oldest.
